// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for a two-requester pipeline (ALU = 0, LSU = 1).
// Round-robin grant into a single register-file write port, registered
// one cycle after acceptance, plus a pending-write scoreboard per register.
module rf_wb_arbiter #(
   parameter int NREQ = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      wb_valid,
   input  logic [NREQ*5-1:0]    wb_rd,
   input  logic [NREQ*32-1:0]   wb_data,
   output logic [NREQ-1:0]      wb_ready,
   input  logic                 iss_valid,
   input  logic [4:0]           iss_rd,
   output logic                 rf_wen,
   output logic [4:0]           rf_wnum,
   output logic [31:0]          rf_wd,
   output logic [31:0]          rd_busy
);

   // index of the requester granted on the most recent completed transfer
   logic        last_grant;
   logic        xfer;
   logic        sel;
   logic [4:0]  sel_rd;
   logic [31:0] sel_data;
   logic [31:0] busy_nxt;

   // grant: lone requester wins; on a tie the one not granted last wins.
   // wb_ready is held low throughout reset.
   always_comb begin
      wb_ready = '0;
      if (rst_n) begin
         case (wb_valid)
            2'b01:   wb_ready = 2'b01;
            2'b10:   wb_ready = 2'b10;
            2'b11:   wb_ready = last_grant ? 2'b01 : 2'b10;
            default: wb_ready = 2'b00;
         endcase
      end
   end

   // select the accepted request's payload
   always_comb begin
      xfer     = |(wb_valid & wb_ready);
      sel      = wb_ready[1];
      sel_rd   = sel ? wb_rd[9:5]    : wb_rd[4:0];
      sel_data = sel ? wb_data[63:32] : wb_data[31:0];
   end

   // round-robin pointer moves only when a transfer completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (xfer) begin
         last_grant <= sel;
      end
   end

   // register-file write stage; x0 targets are accepted but never written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wen  <= 1'b0;
         rf_wnum <= '0;
         rf_wd   <= '0;
      end else begin
         rf_wen <= xfer && (sel_rd != 5'd0);
         if (xfer) begin
            rf_wnum <= sel_rd;
            rf_wd   <= sel_data;
         end
      end
   end

   // scoreboard next state: clear on commit, then set on issue so set wins
   always_comb begin
      busy_nxt = rd_busy;
      if (rf_wen) begin
         busy_nxt[rf_wnum] = 1'b0;
      end
      if (iss_valid && (iss_rd != 5'd0)) begin
         busy_nxt[iss_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   // scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_busy <= '0;
      end else begin
         rd_busy <= busy_nxt;
      end
   end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of writeback requesters (fixed at 2 for this revision; index 0 = ALU, 1 = LSU).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports wb_valid  input  2, wb_rd  input  2x5, wb_data  input  2x32: per-requester writeback request, destination register and value.
REQ-005 SHALL have port wb_ready  output  2  per-requester acceptance; a transfer occurs on an edge where wb_valid[i] and wb_ready[i] are both high.
REQ-006 SHALL have ports iss_valid  input  1, iss_rd  input  5: issue-stage notice that an instruction writing iss_rd has issued.
REQ-007 SHALL have ports rf_wen  output  1, rf_wnum  output  5, rf_wd  output  32: drive the register file write port (Wen/Wnum/Wd).
REQ-008 SHALL have port rd_busy  output  32  scoreboard, bit n high = register n has a pending write.

Function
REQ-009 SHALL arbitrate round-robin: one valid requester is granted alone; when both are valid, the requester not granted last is granted.
REQ-010 SHALL hold the last-grant pointer in a register, updated only on a completed transfer.
REQ-011 SHALL derive wb_ready combinationally from the grant: at most one bit high per cycle; wb_ready[i] never high while wb_valid[i] is low.
REQ-012 SHALL require requesters to hold wb_valid, wb_rd and wb_data stable until accepted; the block does not buffer ungranted requests.
REQ-013 SHALL register the accepted request: rf_wen/rf_wnum/rf_wd present it in the cycle after the transfer (latency 1), committing at the following edge.
REQ-014 SHALL accept a request with wb_rd = 0 (ready asserted as normal) but SHALL drive rf_wen low for it; x0 is never written.
REQ-015 SHALL drive rf_wen low in any cycle following no transfer; rf_wnum/rf_wd then hold their previous values.
REQ-016 SHALL sustain one transfer per cycle (back-to-back, alternating under contention).
REQ-017 SHALL set rd_busy[iss_rd] on an edge with iss_valid high and iss_rd != 0.
REQ-018 SHALL clear rd_busy[rf_wnum] on an edge with rf_wen high.
REQ-019 SHALL give set priority over clear when both target the same register on the same edge (bit ends high).
REQ-020 SHALL keep rd_busy[0] constantly 0.
REQ-021 SHALL leave rd_busy unchanged by a writeback to a register whose bit is already 0 (no error flag).

Reset
REQ-022 SHALL, while rst_n is low, force rf_wen = 0, rf_wnum = 0, rf_wd = 0, rd_busy = 0, wb_ready = 0, last-grant pointer = requester 1 (so requester 0 wins the first tie).
REQ-023 SHALL discard, on reset assertion mid-operation, any registered but uncommitted write (rf_wen low immediately and asynchronously).
REQ-024 SHALL resume arbitration on the first rising edge after rst_n deasserts.

Verification
REQ-025 SHALL cover reset: rst_n low mid-stream with rf_wen = 1 -> rf_wen, rf_wnum, rf_wd, rd_busy all 0 before next edge.
REQ-026 SHALL cover single requester: wb_valid = 01, rd = 5, data = 0xDEADBEEF -> wb_ready = 01 same cycle; next cycle rf_wen = 1, rf_wnum = 5, rf_wd = 0xDEADBEEF.
REQ-027 SHALL cover contention: both valid 4 cycles (rd 1/2, data 0x11/0x22) after reset -> grants 0,1,0,1; rf_wnum sequence 1,2,1,2, each one cycle after its grant.
REQ-028 SHALL cover x0: wb_rd = 0, data = 0xFFFFFFFF accepted -> wb_ready = 1, rf_wen stays 0, register file x0 reads 0.
REQ-029 SHALL cover scoreboard: iss_rd = 7 -> rd_busy[7] = 1; writeback rd 7 -> rd_busy[7] = 0 the edge after rf_wen; simultaneous issue 7 and rf_wen with rf_wnum = 7 -> rd_busy[7] stays 1.
REQ-030 SHALL cover integration with the register file: writes of value i to x1..x31 via alternating requesters -> read-back of every register equals i, x0 = 0.
